mem_access_arbiter: RTL and testbench

- Shares the single-port 8-bit MEMORY block between three requesters: one writer (W) and two readers (A, B).
- Arbitrates round-robin and drives MEMORY's write-enable, read-to-a and read-to-b strobes, always one-hot or all-low.
- Pulses a per-reader valid in the cycle that reader's MEMORY output port holds the requested word.
- Sits directly in front of MEMORY. The readers take data straight from MEMORY's oDataOuta / oDataOutb.

---
 rtl/mem_access_arbiter.sv | 71 +++++++
 tb/tb_mem_access_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter sharing a single-port memory between one writer and two readers
module mem_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iWriteReq,
  input  logic [ADDR_WIDTH-1:0] iWriteAddr,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  output logic                  oWriteAck,
  input  logic                  iReadReqA,
  input  logic [ADDR_WIDTH-1:0] iReadAddrA,
  output logic                  oReadAckA,
  output logic                  oReadValidA,
  input  logic                  iReadReqB,
  input  logic [ADDR_WIDTH-1:0] iReadAddrB,
  output logic                  oReadAckB,
  output logic                  oReadValidB,
  output logic                  oMemWriteEnable,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  output logic [DATA_WIDTH-1:0] oMemDataIn,
  output logic [ADDR_WIDTH-1:0] oMemReadAddress,
  output logic                  oMemReadtoa,
  output logic                  oMemReadtob
);
  typedef enum logic [1:0] {REQ_W, REQ_A, REQ_B, REQ_NONE} req_t;
  req_t ptr, last, win, p1, p2;
  logic [2:0] elig;
  function automatic req_t after(req_t r);
    return r == REQ_W ? REQ_A : r == REQ_A ? REQ_B : REQ_W;
  endfunction
  // last-granted requester is masked so a held req is not issued twice
  always_comb begin
    elig = {iReadReqB, iReadReqA, iWriteReq} & ~(3'b001 << last);
    p1 = after(ptr);
    p2 = after(p1);
    win = elig[ptr] ? ptr : elig[p1] ? p1 : elig[p2] ? p2 : REQ_NONE;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr <= REQ_W;
      last <= REQ_NONE;
      oWriteAck <= 1'b0;
      oReadAckA <= 1'b0;
      oReadAckB <= 1'b0;
      oReadValidA <= 1'b0;
      oReadValidB <= 1'b0;
      oMemWriteEnable <= 1'b0;
      oMemReadtoa <= 1'b0;
      oMemReadtob <= 1'b0;
      oMemAddress <= '0;
      oMemDataIn <= '0;
      oMemReadAddress <= '0;
    end else begin
      oMemWriteEnable <= win == REQ_W;
      oWriteAck <= win == REQ_W;
      oMemReadtoa <= win == REQ_A;
      oReadAckA <= win == REQ_A;
      oMemReadtob <= win == REQ_B;
      oReadAckB <= win == REQ_B;
      oReadValidA <= oMemReadtoa;
      oReadValidB <= oMemReadtob;
      oMemAddress <= win == REQ_W ? iWriteAddr : oMemAddress;
      oMemDataIn <= win == REQ_W ? iWriteData : oMemDataIn;
      oMemReadAddress <= win == REQ_A ? iReadAddrA : win == REQ_B ? iReadAddrB : oMemReadAddress;
      ptr <= win == REQ_NONE ? ptr : after(win);
      last <= win;
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed plus random checks of the arbiter against a behavioural model and memory
module tb_mem_access_arbiter;
  logic clk = 0, rst = 1;
  logic wreq = 0, rqa = 0, rqb = 0;
  logic [9:0] waddr = 0, addra = 0, addrb = 0;
  logic [7:0] wdata = 0;
  logic wack, acka, ackb, va, vb, mwe, mra, mrb;
  logic [9:0] maddr, mraddr;
  logic [7:0] mdin;
  logic [7:0] mem [0:1023];
  logic [7:0] outa = 0, outb = 0;
  int tests = 0, fails = 0;
  int ptr_m = 0, last_m = 3, win;
  logic [7:0] gold [0:1023];
  bit known [0:1023];
  logic e_we, e_ra, e_rb, e_va, e_vb;
  logic [9:0] e_addr, e_raddr;
  logic [7:0] e_data, iss_a, iss_b, chk_a, chk_b;
  bit iss_ak, iss_bk, chk_ak, chk_bk;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .Clock(clk), .Reset(rst),
    .iWriteReq(wreq), .iWriteAddr(waddr), .iWriteData(wdata), .oWriteAck(wack),
    .iReadReqA(rqa), .iReadAddrA(addra), .oReadAckA(acka), .oReadValidA(va),
    .iReadReqB(rqb), .iReadAddrB(addrb), .oReadAckB(ackb), .oReadValidB(vb),
    .oMemWriteEnable(mwe), .oMemAddress(maddr), .oMemDataIn(mdin),
    .oMemReadAddress(mraddr), .oMemReadtoa(mra), .oMemReadtob(mrb)
  );

  always @(posedge clk) begin
    if (mwe) mem[maddr] <= mdin;
    if (mra) outa <= mem[mraddr];
    if (mrb) outb <= mem[mraddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] req;
    req = {rqb, rqa, wreq};
    if (rst) begin
      {e_we, e_ra, e_rb, e_va, e_vb} = '0;
      e_addr = 0; e_raddr = 0; e_data = 0;
      ptr_m = 0; last_m = 3;
      iss_ak = 0; iss_bk = 0; chk_ak = 0; chk_bk = 0;
    end else begin
      e_va = e_ra; e_vb = e_rb;
      chk_a = iss_a; chk_ak = iss_ak; chk_b = iss_b; chk_bk = iss_bk;
      iss_ak = 0; iss_bk = 0;
      win = 3;
      for (int k = 2; k >= 0; k--) if (req[(ptr_m + k) % 3] && (ptr_m + k) % 3 != last_m) win = (ptr_m + k) % 3;
      e_we = win == 0; e_ra = win == 1; e_rb = win == 2;
      if (win == 0) begin
        e_addr = waddr; e_data = wdata; gold[waddr] = wdata; known[waddr] = 1;
      end
      if (win == 1) begin
        e_raddr = addra; iss_a = gold[addra]; iss_ak = known[addra];
      end
      if (win == 2) begin
        e_raddr = addrb; iss_b = gold[addrb]; iss_bk = known[addrb];
      end
      if (win != 3) ptr_m = (win + 1) % 3;
      last_m = win;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("strobes", {mwe, mra, mrb, wack, acka, ackb, va, vb}, {e_we, e_ra, e_rb, e_we, e_ra, e_rb, e_va, e_vb});
    chk("mem_addr", maddr, e_addr);
    chk("mem_data", mdin, e_data);
    chk("read_addr", mraddr, e_raddr);
    chk("one_hot", 32'($countones({mwe, mra, mrb})) <= 1, 1);
    if (e_va && chk_ak) chk("data_a", outa, chk_a);
    if (e_vb && chk_bk) chk("data_b", outb, chk_b);
  endtask

  task automatic write_word(input logic [9:0] a, input logic [7:0] d);
    wreq = 1; waddr = a; wdata = d;
    for (int i = 0; i < 4 && wreq; i++) begin
      step();
      if (wack) wreq = 0;
    end
    wreq = 0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) known[i] = 0;
    step(); step();
    rst = 0;
    step();
    write_word(10'h005, 8'hA5);
    chk("write_addr_005", maddr, 10'h005);
    chk("write_data_a5", mdin, 8'hA5);
    rqa = 1; addra = 10'h005;
    step();
    chk("ack_a_005", acka, 1);
    rqa = 0;
    step();
    chk("valid_a_005", va, 1);
    chk("outa_a5", outa, 8'hA5);
    write_word(10'h001, 8'h11);
    write_word(10'h002, 8'h22);
    rqa = 1; addra = 10'h001; rqb = 1; addrb = 10'h002;
    for (int i = 0; i < 6; i++) begin
      step();
      if (acka) rqa = 0;
      if (ackb) rqb = 0;
    end
    wreq = 1; rqa = 1; rqb = 1; waddr = 10'h003; wdata = 8'h33; addra = 10'h001; addrb = 10'h002;
    for (int i = 0; i < 9; i++) step();
    wreq = 0; rqa = 0; rqb = 0;
    step(); step();
    rqb = 1; addrb = 10'h005;
    for (int i = 0; i < 6; i++) step();
    rqb = 0;
    step(); step();
    rqa = 1; addra = 10'h001;
    for (int i = 0; i < 4 && !acka; i++) step();
    chk("ack_before_reset", acka, 1);
    rst = 1; rqa = 0;
    step();
    chk("valid_cancelled", va, 0);
    rst = 0; wreq = 1; rqa = 1; rqb = 1;
    step();
    chk("first_after_reset_w", {wack, acka, ackb}, 3'b100);
    wreq = 0; rqa = 0; rqb = 0;
    step(); step();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 63) == 0;
      wreq = $urandom_range(0, 2) != 0; rqa = $urandom_range(0, 2) != 0; rqb = $urandom_range(0, 2) != 0;
      waddr = 10'($urandom_range(0, 7)); addra = 10'($urandom_range(0, 7)); addrb = 10'($urandom_range(0, 7));
      wdata = 8'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
